// File: rtl/sigma_delta_decimator.sv
// Sinc3 (CIC order 3) decimator: 1-bit bitstream in, signed Q2.16 PCM out, ratio 2^DECIM_LOG2.
// Optional macro SD_DECIM_ROUND_EN: round half up before the final shift instead of truncating.
module sigma_delta_decimator #(
  parameter int DECIM_LOG2 = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  input  logic        din_en,
  output logic [17:0] sample_out,
  output logic        sample_out_rdy
);

  localparam int W  = 2 + 3 * DECIM_LOG2;
  localparam int SH = 3 * DECIM_LOG2 - 16;
  localparam logic [DECIM_LOG2-1:0] CNT_MAX = '1;

  logic signed [W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic signed [W-1:0] cap_q, cap_d;
  logic signed [W-1:0] s_dly_q, s_dly_d, c1_q, c1_d, c1_dly_q, c1_dly_d;
  logic signed [W-1:0] c2_q, c2_d, c2_dly_q, c2_dly_d;
  logic                cap_v_q, cap_v_d, c1_v_q, c1_v_d, c2_v_q, c2_v_d;
  logic [17:0]         sample_q, sample_d;
  logic                rdy_q, rdy_d;
  logic signed [W-1:0] x, c3, c3_adj, c3_sh;

  // Integrators and decimation counter advance only on bit strobes.
  always_comb begin
    x      = din ? W'(1) : '1;
    i1_d   = i1_q;
    i2_d   = i2_q;
    i3_d   = i3_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (din_en) begin
      i1_d   = i1_q + x;
      i2_d   = i2_q + i1_q;
      i3_d   = i3_q + i2_q;
      cnt_d  = cnt_q + 1'b1;
      tick_d = (cnt_q == CNT_MAX);
    end
  end

  // Comb pipeline runs on every clk, one stage per cycle after the tick.
  always_comb begin
    cap_d    = tick_q ? i3_q : cap_q;
    cap_v_d  = tick_q;
    c1_d     = c1_q;
    s_dly_d  = s_dly_q;
    c1_v_d   = cap_v_q;
    c2_d     = c2_q;
    c1_dly_d = c1_dly_q;
    c2_v_d   = c1_v_q;
    c2_dly_d = c2_dly_q;
    sample_d = sample_q;
    rdy_d    = c2_v_q;
    c3       = c2_q - c2_dly_q;
`ifdef SD_DECIM_ROUND_EN
    c3_adj   = c3 + (W'(1) <<< (SH - 1));
`else
    c3_adj   = c3;
`endif
    c3_sh    = c3_adj >>> SH;
    if (cap_v_q) begin
      c1_d    = cap_q - s_dly_q;
      s_dly_d = cap_q;
    end
    if (c1_v_q) begin
      c2_d     = c1_q - c1_dly_q;
      c1_dly_d = c1_q;
    end
    if (c2_v_q) begin
      c2_dly_d = c2_q;
      sample_d = c3_sh[17:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i1_q     <= '0;
      i2_q     <= '0;
      i3_q     <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      cap_q    <= '0;
      cap_v_q  <= 1'b0;
      c1_q     <= '0;
      s_dly_q  <= '0;
      c1_v_q   <= 1'b0;
      c2_q     <= '0;
      c1_dly_q <= '0;
      c2_v_q   <= 1'b0;
      c2_dly_q <= '0;
      sample_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      i1_q     <= i1_d;
      i2_q     <= i2_d;
      i3_q     <= i3_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      cap_q    <= cap_d;
      cap_v_q  <= cap_v_d;
      c1_q     <= c1_d;
      s_dly_q  <= s_dly_d;
      c1_v_q   <= c1_v_d;
      c2_q     <= c2_d;
      c1_dly_q <= c1_dly_d;
      c2_v_q   <= c2_v_d;
      c2_dly_q <= c2_dly_d;
      sample_q <= sample_d;
      rdy_q    <= rdy_d;
    end
  end

  assign sample_out     = sample_q;
  assign sample_out_rdy = rdy_q;

endmodule

// File: doc/sigma_delta_decimator.md
Name: sigma_delta_decimator

Overview:
- Receive side of the 1-bit sigma-delta link. Converts an oversampled bitstream into signed Q2.16 PCM samples.
- Sources: the comparator of an analog sigma-delta ADC, or a loopback of sigma_delta_2order_dac output.
- Sinc3 (CIC, order 3) decimator with power-of-two ratio.
- Output samples use the same 18-bit Q2.16 format and ready-pulse convention as the DAC input side.

Parameters:
- DECIM_LOG2, 11, log2 of decimation ratio R. Legal range 6..12. R = 2^DECIM_LOG2; default R = 2048 (about 48.8 kHz at 100 MHz).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset; asserted (0) clears all state immediately
- din  in  1  bitstream bit: 1 -> +1, 0 -> -1
- din_en  in  1  bit strobe; din consumed only on clk edges with din_en=1
- sample_out  out  18  signed Q2.16 decimated sample; range -1.0..+1.0 (18'h30000..18'h10000)
- sample_out_rdy  out  1  one-clk pulse, sample_out valid and new

Behaviour:
- Reset (reset=0, async): all integrators, combs, delay registers and decimation counter = 0; sample_out=0; sample_out_rdy=0. Deasserting reset mid-stream restarts from zero state; no residual output pulse.
- Internal width W = 2 + 3*DECIM_LOG2 bits, two's complement. All integrator/comb arithmetic is modulo 2^W. Wrap-around is intended and must not be saturated or flagged.
- Input mapping: x = +1 if din=1, else -1, sign-extended to W.
- Integrators, on din_en=1 edges only, pipelined: i1 <= i1 + x; i2 <= i2 + i1; i3 <= i3 + i2. All hold when din_en=0.
- Decimation counter: DECIM_LOG2 bits, increments on din_en=1, wraps R-1 -> 0.
- Tick: the edge where din_en=1 and counter=R-1.
- Comb pipeline, clocked independently of din_en:
  - T+1: capture s = i3.
  - T+2: c1 = s - s_d, s_d <= s.
  - T+3: c2 = c1 - c1_d, c1_d <= c1.
  - T+4: c3 = c2 - c2_d, c2_d <= c2; sample_out <= c3 >> (3*DECIM_LOG2 - 16), truncated toward -inf, low 18 bits; sample_out_rdy=1 for this single clk.
- Latency: sample_out_rdy high exactly 4 clks after the tick edge, independent of din_en during those cycles.
- Gain: constant din=1 gives c3 = R^3, so sample_out = 18'h10000 (+1.0). Constant din=0 gives 18'h30000 (-1.0). No overflow of 18 bits is possible.
- Settling: the first 3 outputs after reset are transient. Output 4 onward is the exact sinc3 response.
- Minimum tick spacing is R din_en pulses (>= R clks), so the comb pipeline never overlaps. din_en may be 1 every clk.
- sample_out holds its value between pulses.

Optional Feature:
- Macro: SD_DECIM_ROUND_EN.
- Defined: before the shift, add 2^(3*DECIM_LOG2-17) to c3 (round half up). Max result is still 18'h10000. Same latency.
- Undefined: plain arithmetic-shift truncation as above.

Test Plan:
- Reset/idle: hold reset=0, toggle din/din_en -> sample_out=0, no sample_out_rdy. Release reset with din_en=0 -> outputs stay 0, no pulse.
- DC +1, DECIM_LOG2=6: din=1, din_en=1 every clk -> rdy pulses every 64 clks, each 4 clks after the tick. 4th and later samples = 18'h10000. Repeat with din=0 -> 18'h30000.
- Alternating din 1,0,1,0 every clk (R=64) -> settled samples = 0. Pattern 1,1,1,0 (mean +0.5) -> settled samples = 18'h08000.
- Gated strobe: din_en=1 every 3rd clk, din=1, R=64 -> rdy spacing 192 clks; settled value 18'h10000; latency still 4 clks after the tick edge.
- Wrap + loopback, default DECIM_LOG2=11:
  - drive din from sigma_delta_2order_dac fed constant 18'h08000 for 2^20 clks, so i3 wraps modulo 2^35;
  - every settled sample within ±18'h00100 of 18'h08000, no glitch at wrap points.
- Reset mid-operation: assert reset 2 clks after a tick, before rdy -> no rdy pulse. After release, first 3 samples transient, 4th correct. Rerun with SD_DECIM_ROUND_EN defined: DC tests still give exactly 18'h10000 / 18'h30000.
